// File: rtl/herloa_error_monitor.sv
// herloa_error_monitor: windowed error-distance statistics for an approximate adder output stream
module herloa_error_monitor #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] cfg_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_s,
  output logic             ed_valid,
  output logic [N:0]       ed_out,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N:0]       ed_max,
  output logic             acc_ovf
);
  localparam int AW1 = ACC_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cfg_q, cfg_d, acc_q, acc_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic             ed_valid_q, ed_valid_d, acc_ovf_q, acc_ovf_d;
  logic [N:0]       ed_out_q, ed_out_d, ed_max_q, ed_max_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic             start_ok, accept;
  logic [N:0]       exact, ed;
  logic [ACC_W:0]   sum_w;

  assign in_ready   = state_q == RUN && acc_q < cfg_q;
  assign done       = state_q == DONE;
  assign ed_valid   = ed_valid_q;
  assign ed_out     = ed_out_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ed_sum     = ed_sum_q;
  assign ed_max     = ed_max_q;
  assign acc_ovf    = acc_ovf_q;

  // next state, stage-1 ED compute and stage-2 accumulation; clear/start override everything
  always_comb begin
    start_ok     = start && !clear && (state_q == IDLE || state_q == DONE);
    accept       = in_valid && in_ready && !clear;
    exact        = {1'b0, in_a} + {1'b0, in_b};
    ed           = (exact >= {1'b0, in_s}) ? exact - {1'b0, in_s} : {1'b0, in_s} - exact;
    sum_w        = {1'b0, ed_sum_q} + AW1'(ed_out_q);
    state_d      = state_q;
    cfg_d        = cfg_q;
    acc_d        = acc_q + CNT_W'(accept);
    ed_valid_d   = accept;
    ed_out_d     = accept ? ed : ed_out_q;
    sample_cnt_d = sample_cnt_q + CNT_W'(ed_valid_q);
    err_cnt_d    = err_cnt_q + CNT_W'(ed_valid_q && ed_out_q != '0);
    ed_max_d     = (ed_valid_q && ed_out_q > ed_max_q) ? ed_out_q : ed_max_q;
    ed_sum_d     = !ed_valid_q ? ed_sum_q : sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    acc_ovf_d    = acc_ovf_q || (ed_valid_q && sum_w[ACC_W]);
    if (state_q == RUN && accept && acc_d == cfg_q) state_d = DRAIN;
    else if (state_q == DRAIN) state_d = DONE;
    if (clear || start_ok) begin
      state_d      = clear ? IDLE : (cfg_samples == '0 ? DONE : RUN);
      cfg_d        = clear ? '0 : cfg_samples;
      acc_d        = '0;
      ed_valid_d   = 1'b0;
      ed_out_d     = '0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      ed_max_d     = '0;
      ed_sum_d     = '0;
      acc_ovf_d    = 1'b0;
    end
  end

  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      acc_q        <= '0;
      ed_valid_q   <= 1'b0;
      ed_out_q     <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      ed_max_q     <= '0;
      ed_sum_q     <= '0;
      acc_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      acc_q        <= acc_d;
      ed_valid_q   <= ed_valid_d;
      ed_out_q     <= ed_out_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ed_max_q     <= ed_max_d;
      ed_sum_q     <= ed_sum_d;
      acc_ovf_q    <= acc_ovf_d;
    end
  end
endmodule

// File: tb/tb_herloa_error_monitor.sv
// tb_herloa_error_monitor: scoreboard bench for the error monitor (default and 17-bit accumulator instances)
module tb_herloa_error_monitor;
  localparam int N = 16, CW = 32, AW = 48, SAW = 17;
  logic clk = 0, rst_n = 0, start = 0, clear = 0, in_valid = 0;
  logic [CW-1:0] cfg = '0;
  logic [N-1:0] a = '0, b = '0, s = '0;
  logic in_ready, ed_valid, done, acc_ovf;
  logic [N:0] ed_out, ed_max;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] ed_sum;
  logic s_in_ready, s_ed_valid, s_done, s_acc_ovf;
  logic [N:0] s_ed_out, s_ed_max;
  logic [CW-1:0] s_sample_cnt, s_err_cnt;
  logic [SAW-1:0] s_ed_sum;
  int n_pass = 0, n_chk = 0;
  logic [N:0] exp_q[$];
  longint m_cnt, m_err, m_sum, m_max;

  herloa_error_monitor #(.N(N), .CNT_W(CW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .cfg_samples(cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(a), .in_b(b), .in_s(s),
    .ed_valid(ed_valid), .ed_out(ed_out), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max), .acc_ovf(acc_ovf));

  herloa_error_monitor #(.N(N), .CNT_W(CW), .ACC_W(SAW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .cfg_samples(cfg),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(a), .in_b(b), .in_s(s),
    .ed_valid(s_ed_valid), .ed_out(s_ed_out), .done(s_done), .sample_cnt(s_sample_cnt),
    .err_cnt(s_err_cnt), .ed_sum(s_ed_sum), .ed_max(s_ed_max), .acc_ovf(s_acc_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [N:0] model_ed(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    logic [N:0] e, v;
    e = {1'b0, x} + {1'b0, y};
    v = {1'b0, z};
    return (e >= v) ? e - v : v - e;
  endfunction

  // scoreboard monitor: every ed strobe must match the oldest expected ED
  always @(negedge clk) begin
    if (ed_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL ed_unexpected: got ed_valid with ed_out=0x%0h expected no strobe", ed_out);
      end else chk("ed_out", {47'b0, ed_out}, {47'b0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [CW-1:0] c);
    cfg = c;
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
  endtask

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    int k;
    logic [N:0] e;
    a = x; b = y; s = z;
    in_valid = 1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
      in_valid = 0;
    end else begin
      e = model_ed(x, y, z);
      exp_q.push_back(e);
      m_cnt++;
      if (e != 0) m_err++;
      m_sum += longint'(e);
      if (longint'(e) > m_max) m_max = longint'(e);
      @(posedge clk);
      #1;
      in_valid = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_ed_valid"}, 64'(ed_valid), 0);
    chk({tag, "_ed_out"}, 64'(ed_out), 0);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), 0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 0);
    chk({tag, "_ed_sum"}, 64'(ed_sum), 0);
    chk({tag, "_ed_max"}, 64'(ed_max), 0);
    chk({tag, "_acc_ovf"}, 64'(acc_ovf), 0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, rs;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    tick(1);

    // directed window of 3 back-to-back samples
    do_start(3);
    chk("t1_ready_after_start", 64'(in_ready), 1);
    send(16'h00FF, 16'h0001, 16'h0100);
    send(16'h00FF, 16'h0001, 16'h00FF);
    send(16'hFFFF, 16'h0001, 16'h0000);
    chk("t1_ready_low", 64'(in_ready), 0);
    chk("t1_done_early", 64'(done), 0);
    tick(1);
    chk("t1_done", 64'(done), 1);
    chk("t1_sample_cnt", 64'(sample_cnt), 3);
    chk("t1_err_cnt", 64'(err_cnt), 2);
    chk("t1_ed_sum", 64'(ed_sum), 64'h10001);
    chk("t1_ed_max", 64'(ed_max), 64'h10000);
    chk("t1_acc_ovf", 64'(acc_ovf), 0);

    // window 100 with random gaps against the model
    model_clear();
    do_start(100);
    for (int i = 0; i < 100; i++) begin
      tick($urandom_range(0, 2));
      ra = 16'($urandom());
      rb = 16'($urandom());
      rs = ($urandom_range(0, 2) == 0) ? ra + rb : 16'($urandom());
      send(ra, rb, rs);
    end
    chk("t2_ready_low", 64'(in_ready), 0);
    in_valid = 1;
    tick(1);
    chk("t2_ready_still_low", 64'(in_ready), 0);
    in_valid = 0;
    chk("t2_done", 64'(done), 1);
    chk("t2_sample_cnt", 64'(sample_cnt), 64'(m_cnt));
    chk("t2_err_cnt", 64'(err_cnt), 64'(m_err));
    chk("t2_ed_sum", 64'(ed_sum), 64'(m_sum));
    chk("t2_ed_max", 64'(ed_max), 64'(m_max));

    // empty window
    a = 16'h1234; b = 16'h1111; s = 16'h0000;
    in_valid = 1;
    do_start(0);
    chk("t3_done", 64'(done), 1);
    chk("t3_ready", 64'(in_ready), 0);
    chk("t3_sample_cnt", 64'(sample_cnt), 0);
    chk("t3_err_cnt", 64'(err_cnt), 0);
    chk("t3_ed_sum", 64'(ed_sum), 0);
    chk("t3_ed_max", 64'(ed_max), 0);
    tick(2);
    in_valid = 0;
    chk("t3_sample_cnt_hold", 64'(sample_cnt), 0);

    // saturation on the 17-bit accumulator instance
    do_start(3);
    repeat (3) send(16'hFFFF, 16'h0001, 16'h0000);
    tick(1);
    chk("t4_sat_sum", 64'(s_ed_sum), 64'h1FFFF);
    chk("t4_sat_ovf", 64'(s_acc_ovf), 1);
    chk("t4_wide_sum", 64'(ed_sum), 64'h30000);
    chk("t4_wide_ovf", 64'(acc_ovf), 0);
    tick(3);
    chk("t4_sat_ovf_sticky", 64'(s_acc_ovf), 1);
    do_start(1);
    chk("t4_sat_ovf_cleared", 64'(s_acc_ovf), 0);
    chk("t4_sat_sum_cleared", 64'(s_ed_sum), 0);
    send(16'h0001, 16'h0001, 16'h0002);
    tick(1);

    // clear one cycle after an accept
    do_start(5);
    send(16'h0003, 16'h0004, 16'h0005);
    clear = 1;
    tick(1);
    clear = 0;
    chk_zero("t5");
    tick(2);
    chk("t5_no_strobe", 64'(ed_valid), 0);

    // asynchronous reset one cycle after an accept
    do_start(5);
    send(16'h0010, 16'h0010, 16'h0030);
    rst_n = 0;
    #2;
    rst_n = 1;
    exp_q.delete();
    chk("t6_ed_valid_async", 64'(ed_valid), 0);
    tick(1);
    chk_zero("t6");

    // start during RUN is ignored
    do_start(4);
    send(16'h0001, 16'h0001, 16'h0001);
    send(16'h0001, 16'h0001, 16'h0001);
    cfg = 1;
    start = 1;
    send(16'h0002, 16'h0002, 16'h0003);
    start = 0;
    send(16'h0004, 16'h0004, 16'h0009);
    tick(1);
    chk("t7_done", 64'(done), 1);
    chk("t7_sample_cnt", 64'(sample_cnt), 4);
    chk("t7_err_cnt", 64'(err_cnt), 4);
    chk("t7_ed_sum", 64'(ed_sum), 4);

    // start and clear together in DONE
    cfg = 2;
    start = 1;
    clear = 1;
    tick(1);
    start = 0;
    clear = 0;
    chk_zero("t8");
    tick(1);
    chk("t8_ready_idle", 64'(in_ready), 0);

    tick(3);
    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/herloa_error_monitor.md
# herloa_error_monitor

Streaming error-metric monitor for the approximate adders (HERLOA and siblings). It consumes the adder's output stream as (operand A, operand B, approximate sum S) samples and recomputes the exact sum with a full N+1-bit carry chain. Over a programmed window of samples it accumulates error distance (ED), error count and maximum ED. It sits downstream of the adder under test in the characterisation harness; the testbench or host reads mean ED and error rate from it after `done`.

## Interface
- `N`, 16: adder operand and approximate-sum width.
- `CNT_W`, 32: width of the sample and error counters and of `cfg_samples`.
- `ACC_W`, 48: width of the saturating ED accumulator; must be ≥ N+1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a window; honoured only in IDLE or DONE.
- `clear` input 1: synchronous abort to IDLE, zeroes all results; has priority over `start`.
- `cfg_samples` input CNT_W: window length; latched on an accepted `start`.
- `in_valid` input 1: sample valid.
- `in_ready` output 1: monitor can accept a sample.
- `in_a`, `in_b` input N: operands fed to the adder.
- `in_s` input N: approximate sum from the adder.
- `ed_valid` output 1: per-sample ED strobe.
- `ed_out` output N+1: |exact − approx| for the strobed sample.
- `done` output 1: window complete; results stable.
- `sample_cnt` output CNT_W: samples accumulated so far.
- `err_cnt` output CNT_W: samples with ED ≠ 0.
- `ed_sum` output ACC_W: sum of ED values; saturates.
- `ed_max` output N+1: largest ED in the window.
- `acc_ovf` output 1: sticky; set when `ed_sum` saturated.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - IDLE/DONE → DONE on `start` when `cfg_samples`=0.
  - RUN → DRAIN when the cfg_samples-th sample is accepted.
  - DRAIN → DONE once stage 1 is empty.
  - DONE → RUN on `start`.
  - Any state → IDLE on `clear`.
- An accepted `start` zeroes `sample_cnt`, `err_cnt`, `ed_sum`, `ed_max` and `acc_ovf` in the same cycle it latches `cfg_samples`.
- `in_ready` = (state==RUN) and (accepted count < latched window). Transfer occurs only when `in_valid`&&`in_ready`. Samples offered outside RUN are ignored and never counted.
- Stage 1 (registered):
  - exact = {0,in_a}+{0,in_b}, N+1 bits, carry kept.
  - ED = |exact − {0,in_s}|, N+1 bits, unsigned.
  - Drives `ed_valid`/`ed_out`.
- Stage 2 (registered) updates on `ed_valid`:
  - `sample_cnt`+1.
  - `err_cnt`+1 if ED≠0.
  - `ed_max`=max(`ed_max`,ED).
  - `ed_sum`+=ED, saturating at 2^ACC_W−1; on saturation `acc_ovf`←1.
- Counters are sized so the window bounds them; `sample_cnt` never exceeds the latched window.
- `clear` in RUN/DRAIN discards in-flight stage-1 data: `ed_valid` goes low the next cycle and no accumulation happens.
- `rst_n` low at any time, including mid-window, has the same effect as `clear`, applied asynchronously.
- Outputs hold their values in DONE until the next accepted `start` or `clear`.

## Timing
- Reset values: `in_ready`=0, `ed_valid`=0, `ed_out`=0, `done`=0, all counters/accumulators=0, `acc_ovf`=0; state IDLE.
- `start` sampled in cycle c → RUN in c+1, with `in_ready` high in c+1.
- Sample accepted in cycle t:
  - `ed_valid`/`ed_out` in cycle t+1.
  - Counters reflect it in cycle t+2.
- Last sample accepted at t:
  - `in_ready` low from t+1.
  - DRAIN in t+1.
  - `done`=1 from t+2, with all results final.
- Throughput is one sample per cycle under back-to-back `in_valid`.
- `cfg_samples`=0 with `start` in c → `done`=1 in c+1, results zero.
- `start` while RUN/DRAIN is ignored. `start` and `clear` in the same cycle → `clear` wins.

## Test plan
- N=16, window 3, back-to-back samples:
  - (0x00FF,0x0001,0x0100) → ED 0.
  - (0x00FF,0x0001,0x00FF) → ED 1.
  - (0xFFFF,0x0001,0x0000) → ED 0x10000.
  - Expect `sample_cnt`=3, `err_cnt`=2, `ed_sum`=0x10001, `ed_max`=0x10000, `done` 2 cycles after the third accept.
- Random `in_valid` gaps, window 100, against a reference model: every `ed_out` matches, and `in_ready` drops after exactly 100 accepts.
- `cfg_samples`=0 → `done` the cycle after `start`; all results 0; no samples accepted.
- ACC_W=17, 3 samples each with ED 0x10000 → `ed_sum`=0x1FFFF, `acc_ovf`=1, which stays 1 until the next `start`.
- `clear` one cycle after an accept in RUN → no `ed_valid` follows; IDLE with zeroed outputs. Repeat with `rst_n` pulsed low mid-window and expect the same result.
- `start` asserted in RUN → ignored, counts unaffected. `start`+`clear` in the same cycle in DONE → IDLE.
